mesi_bus_arbiter: RTL and testbench

- Owns the shared snooping bus between N per-cache MESI controllers.
- Grants the bus round-robin and broadcasts the winner's bus transaction (BusRd / BusRdX / BusUpgr).
- Collects snoop responses from the other caches, then sequences write-back or memory fill.
- Returns completion plus a "shared" indication, which the requester's MESI state machine uses to pick E vs S on a read miss.

---
 rtl/mesi_bus_arbiter_if.sv | 37 +++
 rtl/mesi_bus_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mesi_bus_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mesi_bus_arbiter_if.sv
// Snooping-bus bundle between the MESI bus arbiter (slave) and the cache
// controllers, snoopers and memory that surround it (master).
interface mesi_bus_arbiter_if #(
   parameter int N_CACHES = 4,
   parameter int ADDR_W   = 16
);
   localparam int SRC_W = $clog2(N_CACHES);

   logic [N_CACHES-1:0]        req;
   logic [2*N_CACHES-1:0]      req_op;
   logic [ADDR_W*N_CACHES-1:0] req_addr;
   logic [N_CACHES-1:0]        gnt;
   logic                       bus_valid;
   logic [1:0]                 bus_op;
   logic [ADDR_W-1:0]          bus_addr;
   logic [SRC_W-1:0]           bus_src;
   logic [N_CACHES-1:0]        snoop_shared;
   logic [N_CACHES-1:0]        snoop_dirty;
   logic                       mem_req;
   logic                       mem_we;
   logic                       mem_ack;
   logic [N_CACHES-1:0]        done;
   logic                       done_shared;
   logic                       err;

   modport slave (
      input  req, req_op, req_addr, snoop_shared, snoop_dirty, mem_ack,
      output gnt, bus_valid, bus_op, bus_addr, bus_src, mem_req, mem_we,
             done, done_shared, err
   );

   modport master (
      output req, req_op, req_addr, snoop_shared, snoop_dirty, mem_ack,
      input  gnt, bus_valid, bus_op, bus_addr, bus_src, mem_req, mem_we,
             done, done_shared, err
   );
endinterface

// File: rtl/mesi_bus_arbiter.sv
// Round-robin owner of the shared MESI snooping bus: grant, broadcast, snoop, write-back/fill, done.
// Optional memory-ack watchdog enabled by defining MESI_ARB_TIMEOUT_EN.
module mesi_bus_arbiter #(
   parameter int N_CACHES    = 4,
   parameter int ADDR_W      = 16,
   parameter int SNOOP_WAIT  = 2,
   parameter int TIMEOUT_CYC = 64
) (
   input logic               CLK,
   input logic               CLR,
   mesi_bus_arbiter_if.slave bus
);
   localparam int SRC_W = $clog2(N_CACHES);
   localparam int SNP_W = $clog2(SNOOP_WAIT + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_GRANT = 3'd1;
   localparam logic [2:0] S_SNOOP = 3'd2;
   localparam logic [2:0] S_WB    = 3'd3;
   localparam logic [2:0] S_MEM   = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam logic [1:0] OP_UPGR = 2'b10;

   if (N_CACHES < 2 || N_CACHES > 8 || SNOOP_WAIT < 1 || TIMEOUT_CYC < 1) begin : g_bad_params
      $error("mesi_bus_arbiter: parameter out of range");
   end

   logic [2:0]          state;
   logic [SRC_W-1:0]    rr_ptr;
   logic [SRC_W-1:0]    src;
   logic [1:0]          op;
   logic [ADDR_W-1:0]   addr;
   logic                sh_acc;
   logic                dt_acc;
   logic                err_flag;
   logic [SNP_W-1:0]    snoop_cnt;

   logic [SRC_W-1:0]    pick;
   logic                pick_vld;
   logic [SRC_W-1:0]    cand;
   int                  idx;
   logic [1:0]          pick_op;
   logic [ADDR_W-1:0]   pick_addr;
   logic [N_CACHES-1:0] own;
   logic                sh_nxt;
   logic                dt_nxt;
   logic                tmo_hit;

   // Scan downward so the candidate closest to rr_ptr is the last (winning) assignment.
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      cand     = '0;
      idx      = 0;
      for (int k = N_CACHES - 1; k >= 0; k--) begin
         idx  = (int'(rr_ptr) + k) % N_CACHES;
         cand = SRC_W'(idx);
         if (bus.req[cand]) begin
            pick     = cand;
            pick_vld = 1'b1;
         end
      end
   end

   always_comb begin
      pick_op   = '0;
      pick_addr = '0;
      own       = '0;
      for (int i = 0; i < N_CACHES; i++) begin
         if (SRC_W'(i) == pick) begin
            pick_op   = bus.req_op[2*i +: 2];
            pick_addr = bus.req_addr[ADDR_W*i +: ADDR_W];
         end
         own[i] = (SRC_W'(i) == src);
      end
   end

   // The requester's own snoop lines are ignored; this cycle's inputs count toward the exit decision.
   assign sh_nxt = sh_acc | (|(bus.snoop_shared & ~own));
   assign dt_nxt = dt_acc | (|(bus.snoop_dirty & ~own));

`ifdef MESI_ARB_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] tmo_cnt;

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         tmo_cnt <= '0;
      end else if (state == S_WB || state == S_MEM) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
         tmo_cnt <= '0;
      end
   end

   assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         state     <= S_IDLE;
         rr_ptr    <= '0;
         src       <= '0;
         op        <= '0;
         addr      <= '0;
         sh_acc    <= 1'b0;
         dt_acc    <= 1'b0;
         err_flag  <= 1'b0;
         snoop_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pick_vld) begin
                  src      <= pick;
                  op       <= pick_op;
                  addr     <= pick_addr;
                  sh_acc   <= 1'b0;
                  dt_acc   <= 1'b0;
                  err_flag <= 1'b0;
                  state    <= S_GRANT;
               end
            end
            S_GRANT: begin
               snoop_cnt <= '0;
               state     <= S_SNOOP;
            end
            S_SNOOP: begin
               sh_acc <= sh_nxt;
               dt_acc <= dt_nxt;
               if (snoop_cnt == SNP_W'(SNOOP_WAIT - 1)) begin
                  // A dirty holder supplies the data itself, so write-back replaces any fill.
                  if (dt_nxt) begin
                     state <= S_WB;
                  end else if (op == OP_UPGR) begin
                     state <= S_DONE;
                  end else begin
                     state <= S_MEM;
                  end
               end else begin
                  snoop_cnt <= snoop_cnt + 1'b1;
               end
            end
            S_WB, S_MEM: begin
               if (bus.mem_ack) begin
                  state <= S_DONE;
               end else if (tmo_hit) begin
                  err_flag <= 1'b1;
                  state    <= S_DONE;
               end
            end
            S_DONE: begin
               rr_ptr <= (src == SRC_W'(N_CACHES - 1)) ? '0 : src + 1'b1;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.gnt         = (state != S_IDLE) ? own : '0;
      bus.bus_valid   = (state == S_GRANT);
      bus.mem_req     = (state == S_WB) || (state == S_MEM);
      bus.mem_we      = (state == S_WB);
      bus.done        = (state == S_DONE) ? own : '0;
      bus.done_shared = (state == S_DONE) && (sh_acc || dt_acc) && !err_flag;
      bus.err         = (state == S_DONE) && err_flag;
   end

   assign bus.bus_op   = op;
   assign bus.bus_addr = addr;
   assign bus.bus_src  = src;
endmodule

// File: tb/tb_mesi_bus_arbiter.sv
// Self-checking bench for mesi_bus_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model of the arbitration and snoop rules.
module tb_mesi_bus_arbiter;
   localparam int N   = 4;
   localparam int AW  = 16;
   localparam int SW  = 2;
   localparam int TMO = 8;

   logic CLK = 1'b0;
   logic CLR = 1'b0;
   always #5 CLK = ~CLK;

   mesi_bus_arbiter_if #(.N_CACHES(N), .ADDR_W(AW)) bus ();

   mesi_bus_arbiter #(
      .N_CACHES(N), .ADDR_W(AW), .SNOOP_WAIT(SW), .TIMEOUT_CYC(TMO)
   ) dut (
      .CLK(CLK),
      .CLR(CLR),
      .bus(bus)
   );

   int checks = 0;
   int fails  = 0;

   // model and stimulus state
   int            rr = 0;
   logic [1:0]    cop   [N];
   logic [AW-1:0] caddr [N];
   logic [N-1:0]  pend;
   logic [N-1:0]  sh_pat [SW];
   logic [N-1:0]  dt_pat [SW];
   int            ack_delay;
   bit            stray_ack;
   bit            drop_mid;
   logic [N-1:0]  rearm;

   // observations from one transaction
   int            o_done_cyc, o_valid_cnt, o_wb, o_mem;
   logic [N-1:0]  o_gnt, o_done;
   logic          o_dsh, o_err, o_gnt_bad;
   logic [1:0]    o_op;
   logic [AW-1:0] o_addr;
   logic [1:0]    o_src;

   // expectations for one transaction
   int            e_w, e_done_cyc, e_wb, e_mem;
   logic          e_dsh, e_err;
   logic [1:0]    e_op;
   logic [AW-1:0] e_addr;
   logic [N-1:0]  e_onehot;

   task automatic drive_req();
      for (int i = 0; i < N; i++) begin
         bus.req_op[2*i +: 2]    = cop[i];
         bus.req_addr[AW*i +: AW] = caddr[i];
      end
      bus.req = pend;
   endtask

   task automatic clear_stim();
      for (int j = 0; j < SW; j++) begin
         sh_pat[j] = '0;
         dt_pat[j] = '0;
      end
      ack_delay = 1;
      stray_ack = 1'b0;
      drop_mid  = 1'b0;
      rearm     = '0;
   endtask

   task automatic apply_reset();
      @(posedge CLK); #1;
      CLR = 1'b0;
      pend = '0;
      drive_req();
      bus.snoop_shared = '0;
      bus.snoop_dirty  = '0;
      bus.mem_ack      = 1'b0;
      rr = 0;
      repeat (2) @(posedge CLK);
      #1 CLR = 1'b1;
   endtask

   // Transaction-level model: winner is the pending cache at the smallest forward distance
   // from the pointer; the phase and flags follow from the OR of the other caches' snoops.
   task automatic model_txn();
      int best, d;
      logic sh, dt;
      best = N;
      e_w  = 0;
      for (int i = 0; i < N; i++) begin
         if (pend[i] && ((i - rr + N) % N) < best) begin
            best = (i - rr + N) % N;
            e_w  = i;
         end
      end
      e_onehot = '0;
      e_onehot[e_w] = 1'b1;
      sh = 1'b0;
      dt = 1'b0;
      for (int j = 0; j < SW; j++) begin
         sh = sh | (|(sh_pat[j] & ~e_onehot));
         dt = dt | (|(dt_pat[j] & ~e_onehot));
      end
      d      = (ack_delay == 0) ? TMO : ack_delay;
      e_op   = cop[e_w];
      e_addr = caddr[e_w];
      e_wb   = dt ? d : 0;
      e_mem  = (!dt && e_op != 2'b10) ? d : 0;
      e_err  = (ack_delay == 0) && (e_wb + e_mem > 0);
      e_dsh  = e_err ? 1'b0 : (sh | dt);
      e_done_cyc = 2 + SW + e_wb + e_mem;
      rr = (e_w + 1) % N;
   endtask

   // Drives one transaction from IDLE to the cycle after DONE, recording what the DUT did.
   task automatic run_txn();
      int   cyc, gcyc, ph;
      logic preq, pwe;
      cyc = 0; gcyc = -1; ph = 0; preq = 1'b0; pwe = 1'b0;
      o_done_cyc = -1; o_valid_cnt = 0; o_wb = 0; o_mem = 0;
      o_gnt = '0; o_done = '0; o_dsh = 1'b0; o_err = 1'b0; o_gnt_bad = 1'b0;
      o_op = '0; o_addr = '0; o_src = '0;
      while (cyc < 400) begin
         @(posedge CLK); #1;
         cyc++;
         if (bus.bus_valid) begin
            o_valid_cnt++;
            gcyc   = cyc;
            o_gnt  = bus.gnt;
            o_op   = bus.bus_op;
            o_addr = bus.bus_addr;
            o_src  = bus.bus_src;
            if (drop_mid) begin
               pend = pend & ~bus.gnt;
               drive_req();
            end
         end else if (gcyc > 0 && bus.gnt !== o_gnt) begin
            o_gnt_bad = 1'b1;
         end
         if (gcyc > 0 && cyc > gcyc && cyc <= gcyc + SW) begin
            bus.snoop_shared = sh_pat[cyc-gcyc-1];
            bus.snoop_dirty  = dt_pat[cyc-gcyc-1];
         end else begin
            bus.snoop_shared = '0;
            bus.snoop_dirty  = '0;
         end
         if (bus.mem_req) begin
            if (!preq || bus.mem_we != pwe) ph = 0;
            ph++;
            if (bus.mem_we) o_wb++;
            else o_mem++;
            bus.mem_ack = (ack_delay != 0 && ph == ack_delay);
         end else begin
            bus.mem_ack = stray_ack && gcyc > 0 && cyc > gcyc && cyc <= gcyc + SW;
         end
         preq = bus.mem_req;
         pwe  = bus.mem_we;
         if (|bus.done) begin
            o_done     = bus.done;
            o_dsh      = bus.done_shared;
            o_err      = bus.err;
            o_done_cyc = cyc;
            bus.mem_ack = 1'b0;
            pend = (pend & ~bus.done) | rearm;
            rearm = '0;
            drive_req();
            @(posedge CLK); #1;
            break;
         end
      end
      bus.mem_ack      = 1'b0;
      bus.snoop_shared = '0;
      bus.snoop_dirty  = '0;
   endtask

   task automatic test_reset();
      checks++; if (bus.gnt !== '0) begin fails++; $display("FAIL reset_gnt: got %b want 0", bus.gnt); end
      checks++; if (bus.bus_valid !== 1'b0) begin fails++; $display("FAIL reset_bus_valid: got %b want 0", bus.bus_valid); end
      checks++; if ({bus.bus_op, bus.bus_addr, bus.bus_src} !== '0) begin fails++; $display("FAIL reset_bus_fields: op %b addr %h src %0d want 0", bus.bus_op, bus.bus_addr, bus.bus_src); end
      checks++; if ({bus.mem_req, bus.mem_we} !== 2'b00) begin fails++; $display("FAIL reset_mem: got %b want 00", {bus.mem_req, bus.mem_we}); end
      checks++; if ({bus.done, bus.done_shared, bus.err} !== '0) begin fails++; $display("FAIL reset_done: got %b want 0", {bus.done, bus.done_shared, bus.err}); end
      repeat (3) @(posedge CLK);
      #1;
      checks++; if (bus.gnt !== '0 || bus.bus_valid !== 1'b0) begin fails++; $display("FAIL idle_no_req: gnt %b valid %b want 0", bus.gnt, bus.bus_valid); end
   endtask

   task automatic test_single_upgr();
      clear_stim();
      cop[0] = 2'b10; caddr[0] = 16'h0abc; pend = 4'b0001;
      model_txn(); drive_req(); run_txn();
      checks++; if (o_gnt !== e_onehot) begin fails++; $display("FAIL upgr_gnt: got %b want %b", o_gnt, e_onehot); end
      checks++; if (o_valid_cnt !== 1) begin fails++; $display("FAIL upgr_bus_valid_cycles: got %0d want 1", o_valid_cnt); end
      checks++; if (o_done !== e_onehot) begin fails++; $display("FAIL upgr_done: got %b want %b", o_done, e_onehot); end
      checks++; if (o_done_cyc !== e_done_cyc) begin fails++; $display("FAIL upgr_latency: got %0d want %0d", o_done_cyc, e_done_cyc); end
      checks++; if (o_dsh !== 1'b0) begin fails++; $display("FAIL upgr_done_shared: got %b want 0", o_dsh); end
      checks++; if (o_wb + o_mem !== 0) begin fails++; $display("FAIL upgr_mem_req_cycles: got %0d want 0", o_wb + o_mem); end
      checks++; if (bus.gnt !== '0) begin fails++; $display("FAIL upgr_gnt_drop: got %b want 0", bus.gnt); end
   endtask

   task automatic test_read_shared();
      clear_stim();
      cop[2] = 2'b00; caddr[2] = 16'h1234; pend = 4'b0100;
      sh_pat[0] = 4'b0010; ack_delay = 3;
      model_txn(); drive_req(); run_txn();
      checks++; if (o_src !== 2'(e_w)) begin fails++; $display("FAIL rd_src: got %0d want %0d", o_src, e_w); end
      checks++; if (o_addr !== e_addr) begin fails++; $display("FAIL rd_addr: got %h want %h", o_addr, e_addr); end
      checks++; if (o_mem !== e_mem || o_wb !== e_wb) begin fails++; $display("FAIL rd_phases: mem %0d wb %0d want mem %0d wb %0d", o_mem, o_wb, e_mem, e_wb); end
      checks++; if (o_done !== e_onehot) begin fails++; $display("FAIL rd_done: got %b want %b", o_done, e_onehot); end
      checks++; if (o_dsh !== e_dsh) begin fails++; $display("FAIL rd_done_shared: got %b want %b", o_dsh, e_dsh); end
      checks++; if (o_done_cyc !== e_done_cyc) begin fails++; $display("FAIL rd_latency: got %0d want %0d", o_done_cyc, e_done_cyc); end
   endtask

   task automatic test_reset_mid_snoop();
      int done_seen;
      clear_stim();
      cop[1] = 2'b00; caddr[1] = 16'h0042; pend = 4'b0010;
      drive_req();
      repeat (2) begin @(posedge CLK); #1; end
      CLR = 1'b0;
      #1;
      checks++; if ({bus.gnt, bus.bus_valid, bus.bus_op, bus.bus_addr, bus.bus_src, bus.mem_req, bus.mem_we, bus.done, bus.done_shared, bus.err} !== '0) begin
         fails++; $display("FAIL midsnoop_reset_outputs: gnt %b op %b addr %h src %0d done %b want all 0", bus.gnt, bus.bus_op, bus.bus_addr, bus.bus_src, bus.done);
      end
      pend = '0; drive_req(); rr = 0;
      done_seen = 0;
      repeat (3) begin @(posedge CLK); #1; if (|bus.done) done_seen++; end
      CLR = 1'b1;
      repeat (2) begin @(posedge CLK); #1; if (|bus.done) done_seen++; end
      checks++; if (done_seen !== 0) begin fails++; $display("FAIL midsnoop_no_done: got %0d done cycles want 0", done_seen); end
      cop[3] = 2'b00; caddr[3] = 16'h3333; pend = 4'b1010;
      model_txn(); drive_req(); run_txn();
      checks++; if (o_src !== 2'(e_w)) begin fails++; $display("FAIL midsnoop_rr_cleared: got %0d want %0d", o_src, e_w); end
      model_txn(); run_txn();
      checks++; if (o_done !== e_onehot) begin fails++; $display("FAIL midsnoop_second: got %b want %b", o_done, e_onehot); end
   endtask

   task automatic test_dirty();
      clear_stim();
      cop[3] = 2'b01; caddr[3] = 16'h7700; pend = 4'b1000;
      dt_pat[0] = 4'b0001; ack_delay = 2;
      model_txn(); drive_req(); run_txn();
      checks++; if (o_wb !== e_wb || o_mem !== e_mem) begin fails++; $display("FAIL dirty_wb_phase: wb %0d mem %0d want wb %0d mem %0d", o_wb, o_mem, e_wb, e_mem); end
      checks++; if (o_done !== e_onehot || o_dsh !== e_dsh) begin fails++; $display("FAIL dirty_done: done %b sh %b want %b %b", o_done, o_dsh, e_onehot, e_dsh); end
      clear_stim();
      pend = 4'b1000; dt_pat[1] = 4'b1000; ack_delay = 2;
      model_txn(); drive_req(); run_txn();
      checks++; if (o_wb !== e_wb || o_mem !== e_mem) begin fails++; $display("FAIL dirty_own_masked: wb %0d mem %0d want wb %0d mem %0d", o_wb, o_mem, e_wb, e_mem); end
      checks++; if (o_dsh !== e_dsh) begin fails++; $display("FAIL dirty_own_shared: got %b want %b", o_dsh, e_dsh); end
      clear_stim();
      pend = 4'b1000; dt_pat[0] = 4'b0011; dt_pat[1] = 4'b0100; ack_delay = 2;
      model_txn(); drive_req(); run_txn();
      checks++; if (o_wb !== e_wb || o_mem !== e_mem || o_done_cyc !== e_done_cyc) begin fails++; $display("FAIL dirty_multi: wb %0d mem %0d cyc %0d want %0d %0d %0d", o_wb, o_mem, o_done_cyc, e_wb, e_mem, e_done_cyc); end
   endtask

   task automatic test_round_robin();
      apply_reset();
      clear_stim();
      for (int i = 0; i < N; i++) begin cop[i] = 2'b00; caddr[i] = AW'(16'h1000 + i); end
      pend = 4'b1111;
      drive_req();
      for (int t = 0; t < 2 * N; t++) begin
         model_txn();
         rearm = e_onehot;
         ack_delay = 1;
         run_txn();
         checks++; if (o_src !== 2'(e_w) || o_done !== e_onehot) begin fails++; $display("FAIL rr_order_%0d: src %0d done %b want %0d", t, o_src, o_done, e_w); end
      end
      clear_stim();
      pend = '0; drive_req();
      repeat (3) @(posedge CLK);
      #1;
   endtask

   task automatic test_boundaries();
      clear_stim();
      cop[2] = 2'b11; caddr[2] = 16'hbeef; pend = 4'b0100;
      stray_ack = 1'b1; drop_mid = 1'b1; ack_delay = 1;
      model_txn(); drive_req(); run_txn();
      checks++; if (o_mem !== e_mem || o_wb !== e_wb) begin fails++; $display("FAIL bnd_one_cycle_fill: mem %0d wb %0d want %0d %0d", o_mem, o_wb, e_mem, e_wb); end
      checks++; if (o_done !== e_onehot || o_done_cyc !== e_done_cyc) begin fails++; $display("FAIL bnd_drop_req_completes: done %b cyc %0d want %b %0d", o_done, o_done_cyc, e_onehot, e_done_cyc); end
      checks++; if (o_op !== e_op || o_addr !== e_addr) begin fails++; $display("FAIL bnd_latched: op %b addr %h want %b %h", o_op, o_addr, e_op, e_addr); end
   endtask

   task automatic test_timeout();
`ifdef MESI_ARB_TIMEOUT_EN
      clear_stim();
      cop[0] = 2'b00; caddr[0] = 16'h0f0f; pend = 4'b0001;
      sh_pat[0] = 4'b0010; ack_delay = 0;
      model_txn(); drive_req(); run_txn();
      checks++; if (o_err !== e_err) begin fails++; $display("FAIL tmo_err: got %b want %b", o_err, e_err); end
      checks++; if (o_mem !== e_mem) begin fails++; $display("FAIL tmo_mem_cycles: got %0d want %0d", o_mem, e_mem); end
      checks++; if (o_dsh !== e_dsh || o_done_cyc !== e_done_cyc) begin fails++; $display("FAIL tmo_done: sh %b cyc %0d want %b %0d", o_dsh, o_done_cyc, e_dsh, e_done_cyc); end
`else
      int mem_cyc, done_cyc, err_cyc;
      clear_stim();
      cop[0] = 2'b00; caddr[0] = 16'h0f0f; pend = 4'b0001;
      drive_req();
      mem_cyc = 0; done_cyc = 0; err_cyc = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge CLK); #1;
         if (bus.mem_req) mem_cyc++;
         if (|bus.done) done_cyc++;
         if (bus.err) err_cyc++;
      end
      checks++; if (mem_cyc !== 40 - (1 + SW)) begin fails++; $display("FAIL notmo_waits: mem cycles %0d want %0d", mem_cyc, 40 - (1 + SW)); end
      checks++; if (done_cyc !== 0 || err_cyc !== 0) begin fails++; $display("FAIL notmo_no_done: done %0d err %0d want 0", done_cyc, err_cyc); end
      apply_reset();
`endif
   endtask

   task automatic test_random();
      for (int t = 0; t < 40; t++) begin
         clear_stim();
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1) begin
               pend[i]  = 1'b1;
               cop[i]   = 2'($urandom_range(0, 3));
               caddr[i] = AW'($urandom);
            end
         end
         if (pend == '0) begin
            pend[0] = 1'b1; cop[0] = 2'($urandom_range(0, 3)); caddr[0] = AW'($urandom);
         end
         for (int j = 0; j < SW; j++) begin
            sh_pat[j] = N'($urandom) & N'($urandom);
            dt_pat[j] = '0;
            if ($urandom_range(0, 3) == 0) dt_pat[j][$urandom_range(0, N-1)] = 1'b1;
         end
         ack_delay = $urandom_range(1, 4);
         stray_ack = 1'($urandom_range(0, 1));
         drop_mid  = ($urandom_range(0, 4) == 0);
         model_txn(); drive_req(); run_txn();
         checks++; if (o_src !== 2'(e_w) || o_done !== e_onehot || o_gnt !== e_onehot) begin fails++; $display("FAIL rnd_%0d_winner: src %0d gnt %b done %b want %0d", t, o_src, o_gnt, o_done, e_w); end
         checks++; if (o_wb !== e_wb || o_mem !== e_mem) begin fails++; $display("FAIL rnd_%0d_phases: wb %0d mem %0d want %0d %0d", t, o_wb, o_mem, e_wb, e_mem); end
         checks++; if (o_dsh !== e_dsh || o_err !== e_err) begin fails++; $display("FAIL rnd_%0d_flags: sh %b err %b want %b %b", t, o_dsh, o_err, e_dsh, e_err); end
         checks++; if (o_done_cyc !== e_done_cyc || o_valid_cnt !== 1 || o_gnt_bad !== 1'b0) begin fails++; $display("FAIL rnd_%0d_timing: cyc %0d valid %0d gnt_unstable %b want %0d 1 0", t, o_done_cyc, o_valid_cnt, o_gnt_bad, e_done_cyc); end
         checks++; if (o_op !== e_op || o_addr !== e_addr) begin fails++; $display("FAIL rnd_%0d_bus: op %b addr %h want %b %h", t, o_op, o_addr, e_op, e_addr); end
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin cop[i] = '0; caddr[i] = '0; end
      pend = '0;
      bus.req = '0; bus.req_op = '0; bus.req_addr = '0;
      bus.snoop_shared = '0; bus.snoop_dirty = '0; bus.mem_ack = 1'b0;
      clear_stim();
      apply_reset();
      #1;
      test_reset();
      test_single_upgr();
      test_read_shared();
      test_reset_mid_snoop();
      test_dirty();
      test_round_robin();
      test_boundaries();
      test_timeout();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
